// File: rtl/i2c_byte_sequencer_if.sv
// Command/result bundle between the I2C master command FSM and the byte sequencer.
// master = command FSM side, slave = byte sequencer side.
interface i2c_byte_sequencer_if #(
    parameter int NBITS = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_rd;
    logic [NBITS-1:0] cmd_data;
    logic             cmd_ack;
    logic             busy;
    logic             done;
    logic [NBITS-1:0] rx_data;
    logic             ack_rx;
    logic             arb_lost;

    modport master (
        output cmd_valid,
        output cmd_rd,
        output cmd_data,
        output cmd_ack,
        input  cmd_ready,
        input  busy,
        input  done,
        input  rx_data,
        input  ack_rx,
        input  arb_lost
    );

    modport slave (
        input  cmd_valid,
        input  cmd_rd,
        input  cmd_data,
        input  cmd_ack,
        output cmd_ready,
        output busy,
        output done,
        output rx_data,
        output ack_rx,
        output arb_lost
    );
endinterface

// File: rtl/i2c_byte_sequencer.sv
// I2C byte sequencer: drives an external 8-bit shift register through one data byte + ACK slot.
// Optional arbitration-lost detection on TX bytes is enabled by defining I2C_ARB_LOST_EN.
module i2c_byte_sequencer #(
    parameter int NBITS = 8,
    parameter int CNT_W = $clog2(NBITS) + 1
) (
    input  logic             clk,
    input  logic             Clear,
    i2c_byte_sequencer_if.slave cmd,
    input  logic             bit_tick,
    input  logic             sample_tick,
    input  logic             sda_in,
    output logic             sda_out,
    output logic [2:0]       sr_sel,
    output logic [NBITS-1:0] sr_d,
    output logic             sr_msb_in,
    output logic             sr_lsb_in,
    input  logic [NBITS-1:0] sr_q
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] SEL_HOLD = 3'd0;
    localparam logic [2:0] SEL_LOAD = 3'd1;
    localparam logic [2:0] SEL_SHL  = 3'd3;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic             samp;
    logic             rd_q;
    logic             cack_q;
    logic [NBITS-1:0] rx_q;
    logic             ackrx_q;

    logic             accept;
    logic             shift_bit;
    logic             last_bit;
    logic             arb_hit;

    assign accept    = (state == S_IDLE) && cmd.cmd_valid;
    // A bit strobe coinciding with its sample strobe takes the live line value.
    assign shift_bit = sample_tick ? sda_in : samp;
    assign last_bit  = (bit_cnt == LAST_BIT);

    assign cmd.cmd_ready = (state == S_IDLE);
    assign cmd.busy      = (state != S_IDLE);
    assign cmd.done      = (state == S_DONE);
    assign cmd.rx_data   = rx_q;
    assign cmd.ack_rx    = ackrx_q;

    assign sr_d      = cmd.cmd_rd ? {NBITS{1'b1}} : cmd.cmd_data;
    assign sr_msb_in = 1'b0;
    assign sr_lsb_in = shift_bit;

`ifdef I2C_ARB_LOST_EN
    logic arb_q;

    // Another master pulled SDA low while we released it: we lost the bus.
    assign arb_hit = (state == S_DATA) && !rd_q && sample_tick
                     && sda_out && !sda_in;

    // Sticky arbitration-lost flag, cleared when the next command is taken.
    always_ff @(posedge clk) begin
        if (!Clear) begin
            arb_q <= 1'b0;
        end else if (accept) begin
            arb_q <= 1'b0;
        end else if (arb_hit) begin
            arb_q <= 1'b1;
        end
    end

    assign cmd.arb_lost = arb_q;
`else
    assign arb_hit      = 1'b0;
    assign cmd.arb_lost = 1'b0;
`endif

    // Shift-register control: load on accept, shift on each data bit strobe.
    always_comb begin
        sr_sel = SEL_HOLD;
        if (accept) begin
            sr_sel = SEL_LOAD;
        end else if ((state == S_DATA) && bit_tick && !arb_hit) begin
            sr_sel = SEL_SHL;
        end
    end

    // SDA drive: register MSB during data, ACK/NACK on RX, released otherwise.
    always_comb begin
        sda_out = 1'b1;
        unique case (state)
            S_DATA:  sda_out = sr_q[NBITS-1];
            S_ACK:   sda_out = rd_q ? cack_q : 1'b1;
            default: sda_out = 1'b1;
        endcase
    end

    // Byte sequencing: IDLE -> DATA -> ACK -> DONE -> IDLE.
    always_ff @(posedge clk) begin
        if (!Clear) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            rd_q    <= 1'b0;
            cack_q  <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        rd_q    <= cmd.cmd_rd;
                        cack_q  <= cmd.cmd_ack;
                        bit_cnt <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (arb_hit) begin
                        state <= S_DONE;
                    end else if (bit_tick) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (last_bit) begin
                            state <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    if (bit_tick) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Sampled SDA value, consumed by the following bit strobe.
    always_ff @(posedge clk) begin
        if (!Clear) begin
            samp <= 1'b1;
        end else if ((state == S_DATA) && sample_tick) begin
            samp <= sda_in;
        end
    end

    // Received byte: the completed register value as the last bit shifts in.
    always_ff @(posedge clk) begin
        if (!Clear) begin
            rx_q <= '0;
        end else if ((state == S_DATA) && bit_tick && last_bit
                     && rd_q && !arb_hit) begin
            rx_q <= {sr_q[NBITS-2:0], shift_bit};
        end
    end

    // Slave ACK after a transmitted byte.
    always_ff @(posedge clk) begin
        if (!Clear) begin
            ackrx_q <= 1'b1;
        end else if ((state == S_ACK) && !rd_q && sample_tick) begin
            ackrx_q <= sda_in;
        end
    end

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// Bench for i2c_byte_sequencer: transaction-level model + per-cycle compare,
// with hand-computed literal checks on directed bytes.
module tb_i2c_byte_sequencer;

    logic       clk = 1'b0;
    logic       Clear = 1'b0;
    logic       bit_tick = 1'b0;
    logic       sample_tick = 1'b0;
    logic       drv = 1'b1;
    logic       sda_in;
    logic       sda_out;
    logic [2:0] sr_sel;
    logic [7:0] sr_d;
    logic       sr_msb_in;
    logic       sr_lsb_in;
    logic [7:0] sr_q = 8'h00;

    int errors = 0;
    int checks = 0;
    int ncyc = 0;
    int dcount = 0;
    logic obs[$];

    i2c_byte_sequencer_if #(.NBITS(8)) cmd ();

    i2c_byte_sequencer #(.NBITS(8)) dut (
        .clk         (clk),
        .Clear       (Clear),
        .cmd         (cmd),
        .bit_tick    (bit_tick),
        .sample_tick (sample_tick),
        .sda_in      (sda_in),
        .sda_out     (sda_out),
        .sr_sel      (sr_sel),
        .sr_d        (sr_d),
        .sr_msb_in   (sr_msb_in),
        .sr_lsb_in   (sr_lsb_in),
        .sr_q        (sr_q)
    );

    always #5 clk = ~clk;

    // Open-drain bus: the line is low if either side pulls it low.
    assign sda_in = sda_out & drv;

    // External universal shift register.
    always @(posedge clk) begin
        case (sr_sel)
            3'd1:    sr_q <= sr_d;
            3'd3:    sr_q <= {sr_q[6:0], sr_lsb_in};
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model state.
    bit         m_busy = 0;
    bit         m_done = 0;
    bit         m_rd = 0;
    bit         m_cack = 1;
    logic       m_smp = 1;
    logic       m_ack = 1;
    bit         m_arb = 0;
    int         m_bits = 0;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] m_acc = 8'h00;
    logic [7:0] m_rx = 8'h00;

    // Compare DUT against the model mid-cycle, then advance the model.
    always @(negedge clk) begin
        logic       e_sda;
        logic [2:0] e_sel;
        logic       b;
        bit         arb_now;
        bit         in_data;

        in_data = m_busy && !m_done && (m_bits < 8);
        if (!m_busy || m_done) begin
            e_sda = 1'b1;
        end else if (m_bits < 8) begin
            e_sda = m_rd ? 1'b1 : m_byte[3'(7 - m_bits)];
        end else begin
            e_sda = m_rd ? m_cack : 1'b1;
        end
        arb_now = 0;
`ifdef I2C_ARB_LOST_EN
        arb_now = in_data && !m_rd && sample_tick && e_sda && !sda_in;
`endif
        b = sample_tick ? sda_in : m_smp;
        if (!m_busy && cmd.cmd_valid) begin
            e_sel = 3'd1;
        end else if (in_data && bit_tick && !arb_now) begin
            e_sel = 3'd3;
        end else begin
            e_sel = 3'd0;
        end

        if (ncyc > 0) begin
            chk("busy", cmd.busy, m_busy);
            chk("cmd_ready", cmd.cmd_ready, !m_busy);
            chk("done", cmd.done, m_done);
            chk("sda_out", sda_out, e_sda);
            chk("sr_sel", sr_sel, e_sel);
            chk("sr_msb_in", sr_msb_in, 1'b0);
            chk("rx_data", cmd.rx_data, m_rx);
            chk("ack_rx", cmd.ack_rx, m_ack);
            chk("arb_lost", cmd.arb_lost, m_arb);
            if (e_sel == 3'd1) begin
                chk("sr_d", sr_d, cmd.cmd_rd ? 8'hFF : cmd.cmd_data);
            end
            if (e_sel == 3'd3) begin
                chk("sr_lsb_in", sr_lsb_in, b);
            end
            if (sample_tick && m_busy && !m_done) begin
                obs.push_back(sda_out);
            end
            if (cmd.done === 1'b1) begin
                dcount++;
            end
        end

        if (!Clear) begin
            m_busy = 0;
            m_done = 0;
            m_bits = 0;
            m_smp  = 1;
            m_rx   = 8'h00;
            m_ack  = 1;
            m_arb  = 0;
        end else if (m_done) begin
            m_done = 0;
            m_busy = 0;
        end else if (!m_busy) begin
            if (cmd.cmd_valid) begin
                m_busy = 1;
                m_bits = 0;
                m_rd   = cmd.cmd_rd;
                m_cack = cmd.cmd_ack;
                m_byte = cmd.cmd_data;
                m_acc  = 8'h00;
                m_arb  = 0;
            end
        end else if (m_bits < 8) begin
            if (arb_now) begin
                m_arb  = 1;
                m_done = 1;
            end else if (bit_tick) begin
                m_acc = {m_acc[6:0], b};
                m_bits++;
                if (m_bits == 8 && m_rd) begin
                    m_rx = m_acc;
                end
            end
            if (sample_tick) begin
                m_smp = sda_in;
            end
        end else begin
            if (!m_rd && sample_tick) begin
                m_ack = sda_in;
            end
            if (bit_tick) begin
                m_done = 1;
            end
        end
        ncyc++;
    end

    task automatic step(input logic st, input logic bt);
        sample_tick = st;
        bit_tick    = bt;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        bit_tick    = 1'b0;
    endtask

    task automatic slot(input logic d);
        drv = d;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
    endtask

    task automatic issue(input logic rd, input logic [7:0] data,
                         input logic ack);
        cmd.cmd_valid = 1'b1;
        cmd.cmd_rd    = rd;
        cmd.cmd_data  = data;
        cmd.cmd_ack   = ack;
        step(1'b0, 1'b0);
        cmd.cmd_valid = 1'b0;
    endtask

    function automatic logic [8:0] obs_bits();
        logic [8:0] v;
        v = '0;
        foreach (obs[i]) begin
            v = {v[7:0], obs[i]};
        end
        return v;
    endfunction

    initial begin
        logic [7:0] pat;
        int         d0;

        cmd.cmd_valid = 1'b0;
        cmd.cmd_rd    = 1'b0;
        cmd.cmd_data  = 8'h00;
        cmd.cmd_ack   = 1'b0;

        // Reset
        Clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", cmd.busy, 1'b0);
        chk("rst cmd_ready", cmd.cmd_ready, 1'b1);
        chk("rst sda_out", sda_out, 1'b1);
        chk("rst sr_sel", sr_sel, 3'd0);
        chk("rst done", cmd.done, 1'b0);
        chk("rst arb_lost", cmd.arb_lost, 1'b0);
        chk("rst rx_data", cmd.rx_data, 8'h00);
        chk("rst ack_rx", cmd.ack_rx, 1'b1);
        Clear = 1'b1;
        step(1'b0, 1'b0);

        // TX 0xA5, slave ACKs
        obs.delete();
        issue(1'b0, 8'hA5, 1'b0);
        for (int i = 0; i < 8; i++) begin
            slot(1'b1);
        end
        slot(1'b0);
        drv = 1'b1;
        chk("tx done", cmd.done, 1'b1);
        chk("tx nbits", obs.size(), 9);
        chk("tx sda bits", obs_bits(), 9'b101001011);
        chk("tx ack_rx", cmd.ack_rx, 1'b0);
        step(1'b0, 1'b0);
        chk("tx done end", cmd.done, 1'b0);
        chk("tx ready", cmd.cmd_ready, 1'b1);

        // RX 0x3C with NACK
        obs.delete();
        cmd.cmd_valid = 1'b1;
        cmd.cmd_rd    = 1'b1;
        cmd.cmd_data  = 8'h00;
        cmd.cmd_ack   = 1'b1;
        #2;
        chk("rx load sel", sr_sel, 3'd1);
        chk("rx load d", sr_d, 8'hFF);
        @(posedge clk);
        #1;
        cmd.cmd_valid = 1'b0;
        pat = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            slot(pat[7-i]);
        end
        slot(1'b1);
        chk("rx data", cmd.rx_data, 8'h3C);
        chk("rx ack_rx kept", cmd.ack_rx, 1'b0);
        chk("rx sda bits", obs_bits(), 9'h1FF);
        chk("rx done", cmd.done, 1'b1);
        step(1'b0, 1'b0);

        // Held cmd_valid ignored, reset mid-byte
        cmd.cmd_valid = 1'b1;
        cmd.cmd_rd    = 1'b0;
        cmd.cmd_data  = 8'h0F;
        cmd.cmd_ack   = 1'b0;
        step(1'b0, 1'b0);
        chk("hold ready0", cmd.cmd_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            slot(1'b1);
        end
        chk("hold busy", cmd.busy, 1'b1);
        chk("hold ready1", cmd.cmd_ready, 1'b0);
        d0 = dcount;
        Clear = 1'b0;
        cmd.cmd_valid = 1'b0;
        step(1'b0, 1'b0);
        chk("abort busy", cmd.busy, 1'b0);
        chk("abort sda", sda_out, 1'b1);
        chk("abort done", cmd.done, 1'b0);
        chk("abort rx_data", cmd.rx_data, 8'h00);
        Clear = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("abort no done", dcount, d0);

        // Coincident sample+bit strobe bypasses the stored sample
        issue(1'b1, 8'h00, 1'b0);
        drv = 1'b1;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        drv = 1'b0;
        sample_tick = 1'b1;
        bit_tick    = 1'b1;
        #2;
        chk("bypass sel", sr_sel, 3'd3);
        chk("bypass lsb", sr_lsb_in, 1'b0);
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        bit_tick    = 1'b0;
        pat = 8'b00110011;
        for (int i = 2; i < 8; i++) begin
            slot(pat[7-i]);
        end
        slot(1'b1);
        chk("bypass rx", cmd.rx_data, 8'hB3);
        chk("bypass done", cmd.done, 1'b1);
        drv = 1'b1;
        step(1'b0, 1'b0);

        // TX 0xFF with the line pulled low at the 3rd sample
        issue(1'b0, 8'hFF, 1'b0);
        slot(1'b1);
        slot(1'b1);
        drv = 1'b0;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
`ifdef I2C_ARB_LOST_EN
        chk("arb done", cmd.done, 1'b1);
        chk("arb flag", cmd.arb_lost, 1'b1);
        chk("arb sda", sda_out, 1'b1);
        drv = 1'b1;
        step(1'b0, 1'b0);
        chk("arb sticky", cmd.arb_lost, 1'b1);
        chk("arb ready", cmd.cmd_ready, 1'b1);
        issue(1'b0, 8'h00, 1'b0);
        chk("arb cleared", cmd.arb_lost, 1'b0);
        for (int i = 0; i < 8; i++) begin
            slot(1'b1);
        end
        slot(1'b0);
        chk("arb next done", cmd.done, 1'b1);
        step(1'b0, 1'b0);
`else
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            slot(1'b1);
        end
        slot(1'b0);
        chk("noarb done", cmd.done, 1'b1);
        chk("noarb flag", cmd.arb_lost, 1'b0);
        chk("noarb ack", cmd.ack_rx, 1'b0);
        drv = 1'b1;
        step(1'b0, 1'b0);
`endif

        step(1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
